// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen
// Purpose  : Pre-IF next-PC sequencer. Holds the fetch PC and applies flush,
//            misprediction-correction and delay-slot-aware taken redirects.
// Revision : 1.0  initial release
// ============================================================================
module fetch_pc_gen #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush_ex,
   input  logic        flush_eret,
   input  logic        flush_tlb,
   input  logic [31:0] flush_target,
   input  logic        bpu_flush,
   input  logic        bpu_is_correction,
   input  logic [31:0] bpu_correct_target,
   input  logic        pred_valid,
   input  logic        pred_br_taken,
   input  logic [31:0] pred_target,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic        if_valid,
   output logic        if_adel,
   output logic        correct_finish
);

   typedef enum logic [1:0] {
      ST_SEQ     = 2'd0,
      ST_WAIT_DS = 2'd1,
      ST_CORR    = 2'd2
   } state_t;

   localparam logic [31:0] c_PC_STEP = 32'd4;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_pending;
   logic        r_kill;

   logic        w_flush;
   logic        w_corr_redirect;
   logic        w_redirect_any;
   logic        w_accept;
   logic        w_take;
   logic        w_ds_release;
   logic [31:0] w_pc_inc;

   assign w_flush         = flush_ex | flush_eret | flush_tlb;
   assign w_corr_redirect = bpu_flush & bpu_is_correction;
   assign w_redirect_any  = w_flush | w_corr_redirect;

   // No request is issued in a redirect cycle: the PC on the bus is stale.
   assign if_valid = ~reset & ~w_redirect_any;
   assign w_accept = if_valid & if_ready;

   // A prediction right after any redirect describes a squashed fetch.
   assign w_take       = pred_valid & pred_br_taken & ~r_kill & (r_state == ST_SEQ);
   assign w_ds_release = (r_state == ST_WAIT_DS) & w_accept;
   assign w_pc_inc     = r_pc + c_PC_STEP;

   assign if_pc          = r_pc;
   assign if_adel        = if_valid & (r_pc[1:0] != 2'b00);
   assign correct_finish = (r_state == ST_CORR) & w_accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc      <= RESET_PC;
         r_state   <= ST_SEQ;
         r_pending <= 32'd0;
         r_kill    <= 1'b0;
      end else begin
         r_kill <= w_redirect_any | (w_take & w_accept) | w_ds_release;

         if (w_flush) begin
            r_pc      <= flush_target;
            r_state   <= ST_SEQ;
            r_pending <= 32'd0;
         end else if (w_corr_redirect) begin
            r_pc    <= bpu_correct_target;
            r_state <= ST_CORR;
         end else if (w_take) begin
            // if_pc is the delay slot; the target follows once it is accepted.
            if (w_accept) begin
               r_pc <= pred_target;
            end else begin
               r_pending <= pred_target;
               r_state   <= ST_WAIT_DS;
            end
         end else begin
            case (r_state)
               ST_SEQ: begin
                  if (w_accept) r_pc <= w_pc_inc;
               end
               ST_WAIT_DS: begin
                  if (w_accept) begin
                     r_pc    <= r_pending;
                     r_state <= ST_SEQ;
                  end
               end
               ST_CORR: begin
                  if (w_accept) begin
                     r_pc    <= w_pc_inc;
                     r_state <= ST_SEQ;
                  end
               end
               default: r_state <= ST_SEQ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_gen
// Purpose  : Directed self-checking bench for fetch_pc_gen.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_pc_gen;

   logic        clk;
   logic        reset;
   logic        flush_ex, flush_eret, flush_tlb;
   logic [31:0] flush_target;
   logic        bpu_flush, bpu_is_correction;
   logic [31:0] bpu_correct_target;
   logic        pred_valid, pred_br_taken;
   logic [31:0] pred_target;
   logic        if_ready;
   logic [31:0] if_pc;
   logic        if_valid, if_adel, correct_finish;

   int n_vec = 0;
   int n_err = 0;

   fetch_pc_gen dut (
      .clk                (clk),
      .reset              (reset),
      .flush_ex           (flush_ex),
      .flush_eret         (flush_eret),
      .flush_tlb          (flush_tlb),
      .flush_target       (flush_target),
      .bpu_flush          (bpu_flush),
      .bpu_is_correction  (bpu_is_correction),
      .bpu_correct_target (bpu_correct_target),
      .pred_valid         (pred_valid),
      .pred_br_taken      (pred_br_taken),
      .pred_target        (pred_target),
      .if_ready           (if_ready),
      .if_pc              (if_pc),
      .if_valid           (if_valid),
      .if_adel            (if_adel),
      .correct_finish     (correct_finish)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs are then changed 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush_ex = 0; flush_eret = 0; flush_tlb = 0; flush_target = 32'd0;
      bpu_flush = 0; bpu_is_correction = 0; bpu_correct_target = 32'd0;
      pred_valid = 0; pred_br_taken = 0; pred_target = 32'd0;
      if_ready = 1;
   endtask

   // One-cycle exception flush to 'tgt'; if_pc shows tgt afterwards.
   task automatic flush_to(input logic [31:0] tgt);
      flush_ex = 1; flush_target = tgt;
      tick();
      flush_ex = 0; flush_target = 32'd0;
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      tick(); tick();
      n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", if_valid); end
      n_vec++; if (correct_finish !== 1'b0 || if_adel !== 1'b0) begin n_err++; $display("FAIL reset_outs got cf=%b adel=%b want 0/0", correct_finish, if_adel); end
      reset = 0;
      #1;
      n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'hBFC0_0000) begin n_err++; $display("FAIL reset_pc0 got %h v=%b want bfc00000 v=1", if_pc, if_valid); end
      tick(); #1;
      n_vec++; if (if_pc !== 32'hBFC0_0004) begin n_err++; $display("FAIL reset_pc1 got %h want bfc00004", if_pc); end
      tick(); #1;
      n_vec++; if (if_pc !== 32'hBFC0_0008) begin n_err++; $display("FAIL reset_pc2 got %h want bfc00008", if_pc); end
   endtask

   task automatic test_pred_taken();
      idle_inputs();
      flush_to(32'h0000_1000);
      tick(); #1;
      n_vec++; if (if_pc !== 32'h0000_1004) begin n_err++; $display("FAIL pred_ds got %h want 00001004", if_pc); end
      pred_valid = 1; pred_br_taken = 1; pred_target = 32'h0000_2000;
      tick();
      pred_valid = 0; pred_br_taken = 0;
      #1;
      n_vec++; if (if_pc !== 32'h0000_2000) begin n_err++; $display("FAIL pred_tgt got %h want 00002000", if_pc); end
      tick(); #1;
      n_vec++; if (if_pc !== 32'h0000_2004) begin n_err++; $display("FAIL pred_seq got %h want 00002004", if_pc); end
   endtask

   task automatic test_wait_ds();
      idle_inputs();
      flush_to(32'h0000_1000);
      tick();
      if_ready = 0; pred_valid = 1; pred_br_taken = 1; pred_target = 32'h0000_2000;
      tick();
      pred_target = 32'h0000_7000;  // stale prediction during the stall
      tick();
      pred_valid = 0; pred_br_taken = 0;
      tick(); #1;
      n_vec++; if (if_pc !== 32'h0000_1004) begin n_err++; $display("FAIL wait_hold got %h want 00001004", if_pc); end
      if_ready = 1;
      tick(); #1;
      n_vec++; if (if_pc !== 32'h0000_2000) begin n_err++; $display("FAIL wait_tgt got %h want 00002000", if_pc); end
      tick(); #1;
      n_vec++; if (if_pc !== 32'h0000_2004) begin n_err++; $display("FAIL wait_seq got %h want 00002004", if_pc); end
   endtask

   task automatic test_correction();
      idle_inputs();
      bpu_flush = 1; bpu_is_correction = 1; bpu_correct_target = 32'h0000_3008;
      #1;
      n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL corr_valid got %b want 0", if_valid); end
      tick();
      bpu_flush = 0;
      #1;
      n_vec++; if (if_pc !== 32'h0000_3008 || correct_finish !== 1'b1) begin n_err++; $display("FAIL corr_fin got %h cf=%b want 00003008 cf=1", if_pc, correct_finish); end
      tick();
      bpu_is_correction = 0;
      #1;
      n_vec++; if (if_pc !== 32'h0000_300C || correct_finish !== 1'b0) begin n_err++; $display("FAIL corr_once got %h cf=%b want 0000300c cf=0", if_pc, correct_finish); end
      // bpu_flush without correction is ignored
      bpu_flush = 1;
      tick();
      bpu_flush = 0;
      #1;
      n_vec++; if (if_pc !== 32'h0000_3010) begin n_err++; $display("FAIL corr_nocorr got %h want 00003010", if_pc); end
      // correction interrupted by an exception flush
      bpu_flush = 1; bpu_is_correction = 1; bpu_correct_target = 32'h0000_4000;
      tick();
      bpu_flush = 0; if_ready = 0;
      #1;
      n_vec++; if (correct_finish !== 1'b0 || if_pc !== 32'h0000_4000) begin n_err++; $display("FAIL corr_stall got %h cf=%b want 00004000 cf=0", if_pc, correct_finish); end
      flush_ex = 1; flush_target = 32'hBFC0_0380; if_ready = 1;
      #1;
      n_vec++; if (correct_finish !== 1'b0) begin n_err++; $display("FAIL corr_flushcf got %b want 0", correct_finish); end
      tick();
      flush_ex = 0; bpu_is_correction = 0;
      #1;
      n_vec++; if (if_pc !== 32'hBFC0_0380 || correct_finish !== 1'b0) begin n_err++; $display("FAIL corr_flushpc got %h cf=%b want bfc00380 cf=0", if_pc, correct_finish); end
   endtask

   task automatic test_flush_priority();
      idle_inputs();
      flush_to(32'h0000_5000);
      tick();
      flush_ex = 1; flush_target = 32'hBFC0_0380;
      bpu_flush = 1; bpu_is_correction = 1; bpu_correct_target = 32'h0000_6000;
      pred_valid = 1; pred_br_taken = 1; pred_target = 32'h0000_7000;
      #1;
      n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL prio_valid got %b want 0", if_valid); end
      tick();
      flush_ex = 0; bpu_flush = 0; bpu_is_correction = 0;
      pred_target = 32'h0000_8000;  // must be killed
      #1;
      n_vec++; if (if_pc !== 32'hBFC0_0380 || correct_finish !== 1'b0) begin n_err++; $display("FAIL prio_pc got %h cf=%b want bfc00380 cf=0", if_pc, correct_finish); end
      tick();
      pred_valid = 0; pred_br_taken = 0;
      #1;
      n_vec++; if (if_pc !== 32'hBFC0_0384) begin n_err++; $display("FAIL prio_kill got %h want bfc00384", if_pc); end
      // eret and tlb flushes redirect the same way
      flush_eret = 1; flush_target = 32'h0000_A000;
      tick(); flush_eret = 0; #1;
      n_vec++; if (if_pc !== 32'h0000_A000) begin n_err++; $display("FAIL eret_pc got %h want 0000a000", if_pc); end
      flush_tlb = 1; flush_target = 32'h0000_B004;
      tick(); flush_tlb = 0; #1;
      n_vec++; if (if_pc !== 32'h0000_B004) begin n_err++; $display("FAIL tlb_pc got %h want 0000b004", if_pc); end
   endtask

   task automatic test_wrap_adel();
      idle_inputs();
      flush_to(32'hFFFF_FFFC);
      n_vec++; if (if_adel !== 1'b0 || if_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pre got %h adel=%b want fffffffc adel=0", if_pc, if_adel); end
      tick(); #1;
      n_vec++; if (if_pc !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_pc got %h want 00000000", if_pc); end
      flush_to(32'h0000_2002);
      n_vec++; if (if_adel !== 1'b1 || if_pc !== 32'h0000_2002) begin n_err++; $display("FAIL adel_on got %h adel=%b want 00002002 adel=1", if_pc, if_adel); end
      tick(); #1;
      n_vec++; if (if_adel !== 1'b1 || if_pc !== 32'h0000_2006) begin n_err++; $display("FAIL adel_step got %h adel=%b want 00002006 adel=1", if_pc, if_adel); end
      flush_ex = 1; flush_target = 32'h0000_3000;
      #1;
      n_vec++; if (if_adel !== 1'b0) begin n_err++; $display("FAIL adel_inval got %b want 0", if_adel); end
      tick(); flush_ex = 0;
   endtask

   task automatic test_reset_midop();
      idle_inputs();
      flush_to(32'h0000_1000);
      tick();
      if_ready = 0; pred_valid = 1; pred_br_taken = 1; pred_target = 32'h0000_2000;
      tick();
      pred_valid = 0; pred_br_taken = 0;
      reset = 1;
      tick(); #1;
      n_vec++; if (if_pc !== 32'hBFC0_0000 || if_valid !== 1'b0) begin n_err++; $display("FAIL midrst_pc got %h v=%b want bfc00000 v=0", if_pc, if_valid); end
      reset = 0; if_ready = 1;
      tick(); #1;
      n_vec++; if (if_pc !== 32'hBFC0_0004) begin n_err++; $display("FAIL midrst_seq got %h want bfc00004", if_pc); end
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      test_reset();
      test_pred_taken();
      test_wait_ds();
      test_correction();
      test_flush_priority();
      test_wrap_adel();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
